// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results into A/B, the carry flag and a handshaked OUT port,
// and feeds a registered forwarding bus back to decode.
module wb_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_valid,
  input  logic [3:0] wb_result,
  input  logic       wb_carry,
  input  logic       wb_mem_w,
  input  logic       wb_s_reg,
  input  logic       wb_out_reg,
  input  logic       wb_flag_w,
  input  logic       out_ack,
  output logic       wb_ready,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       carry,
  output logic [3:0] fwd_result,
  output logic       fwd_mem_w,
  output logic       fwd_s_reg,
  output logic [7:0] retired
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t out_state;
  logic       accept;

  // NOTE: ready depends on this cycle's out_ack, so a consumer acking a full OUT slot
  // lets a new instruction retire in the same cycle without a bubble.
  assign wb_ready  = !((out_state == FULL) && !out_ack);
  assign accept    = wb_valid && wb_ready;
  assign out_valid = (out_state == FULL);

  // NOTE: all state is non-blocking so every register samples pre-edge values; the async
  // reset clears the pending OUT value too, so the consumer never needs to ack after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state  <= EMPTY;
      reg_a      <= '0;
      reg_b      <= '0;
      out        <= '0;
      carry      <= 1'b0;
      fwd_result <= '0;
      fwd_mem_w  <= 1'b0;
      fwd_s_reg  <= 1'b0;
      retired    <= '0;
    end else begin
      fwd_mem_w <= accept && wb_mem_w;

      if (accept) begin
        retired    <= retired + 8'd1;
        fwd_result <= wb_result;
        fwd_s_reg  <= wb_s_reg;
        if (wb_flag_w) carry <= wb_carry;
        if (wb_mem_w) begin
          if (wb_s_reg) reg_b <= wb_result;
          else          reg_a <= wb_result;
        end
      end

      case (out_state)
        EMPTY: begin
          if (accept && wb_out_reg) begin
            out       <= wb_result;
            out_state <= FULL;
          end
        end
        FULL: begin
          // Accept is only possible here when out_ack is high.
          if (accept && wb_out_reg) begin
            out       <= wb_result;
            out_state <= FULL;
          end else if (out_ack) begin
            out_state <= EMPTY;
          end
        end
        default: out_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port wb_valid  input  1  execute stage presents a completed instruction.
REQ-004 SHALL have port wb_result  input  4  ALU result to retire.
REQ-005 SHALL have port wb_carry  input  1  carry produced by the ALU.
REQ-006 SHALL have port wb_mem_w  input  1  write wb_result into the A/B register file.
REQ-007 SHALL have port wb_s_reg  input  1  destination select: 0 = A, 1 = B.
REQ-008 SHALL have port wb_out_reg  input  1  write wb_result to the OUT port.
REQ-009 SHALL have port wb_flag_w  input  1  update the carry flag from wb_carry.
REQ-010 SHALL have port out_ack  input  1  external consumer takes the pending OUT value.
REQ-011 SHALL have port wb_ready  output  1  stage can accept this cycle (combinational).
REQ-012 SHALL have ports reg_a, reg_b  output  4 each  architectural registers A and B.
REQ-013 SHALL have port out  output  4  OUT port value.
REQ-014 SHALL have port out_valid  output  1  OUT value pending, not yet acknowledged.
REQ-015 SHALL have port carry  output  1  architectural carry flag, read by decode for JNC.
REQ-016 SHALL have ports fwd_result  output  4, fwd_mem_w  output  1, fwd_s_reg  output  1  forwarding bus to decode (its result/in_mem_w/in_s_reg inputs).
REQ-017 SHALL have port retired  output  8  count of retired instructions.

Function
REQ-018 Accept = wb_valid && wb_ready; all state updates below occur only on accept unless stated.
REQ-019 wb_ready SHALL be 0 exactly when out_valid=1 and out_ack=0; otherwise 1.
REQ-020 On accept with wb_mem_w=1, register selected by wb_s_reg SHALL take wb_result at the edge; other register unchanged.
REQ-021 On accept with wb_flag_w=1, carry SHALL take wb_carry; otherwise carry holds.
REQ-022 OUT handshake FSM, states EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY + accept with wb_out_reg -> FULL, out = wb_result.
  - FULL + out_ack, no OUT write accepted -> EMPTY; out keeps its value.
  - FULL + out_ack + accept with wb_out_reg -> FULL, out = new wb_result.
  - FULL + no out_ack -> FULL, no accept possible (REQ-019).
  - out_ack while EMPTY SHALL be ignored.
REQ-023 wb_mem_w and wb_out_reg both set SHALL write the same wb_result to both destinations in the same cycle.
REQ-024 Forwarding bus SHALL be registered, one-cycle latency: after an accept cycle fwd_result = wb_result, fwd_mem_w = wb_mem_w, fwd_s_reg = wb_s_reg; after a non-accept cycle fwd_mem_w = 0, other fields hold.
REQ-025 retired SHALL increment by 1 per accept, wrapping 255 -> 0.
REQ-026 wb_valid=0 SHALL leave all architectural state unchanged; inputs are don't-care.

Reset
REQ-027 rst=1 SHALL immediately force reg_a=0, reg_b=0, out=0, out_valid=0, carry=0, fwd_result=0, fwd_mem_w=0, fwd_s_reg=0, retired=0, FSM=EMPTY, independent of clk.
REQ-028 Reset mid-handshake SHALL discard any pending OUT value; the consumer sees out_valid drop with no ack required.
REQ-029 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-030 Write A: valid, result=5, mem_w=1, s_reg=0 -> next cycle reg_a=5, reg_b=0, fwd_result=5, fwd_mem_w=1, retired=1; following idle cycle fwd_mem_w=0.
REQ-031 OUT stall: write OUT=9, hold out_ack=0, present result=3, mem_w=1, s_reg=1 -> out_valid=1, wb_ready=0, reg_b stays 0 until out_ack=1; same cycle accepts, reg_b=3.
REQ-032 Ack and new OUT write in the same cycle: FULL with out=9, out_ack=1, accept OUT=0xC -> out=0xC, out_valid stays 1.
REQ-033 Carry: wb_carry=1, flag_w=1 then wb_carry=0, flag_w=0 -> carry=1 after both; then wb_carry=0, flag_w=1 -> carry=0.
REQ-034 Wrap and reset: 256 accepts -> retired=0; assert rst asynchronously while out_valid=1 -> all outputs 0 before the next clk edge.
